vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between VGA scan-out and a drawing client (robot status/sprite writer), plus a built-in clear-screen engine.
- Sits between vga_sync (pixel_x, pixel_y, blank) and the RGB DAC path.
- Display reads take a fixed slot and always win. Writes and clears use every other cycle.
- Framebuffer is 160x120 at 8 bpp, scaled 4x to 640x480.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- SCALE_SH, 2, log2 of screen-to-framebuffer scale
- ADDR_W, 15, RAM address width (FB_W*FB_H = 19200 <= 2^15)
- DATA_W, 8, pixel width (RGB332)

Ports:
- clock50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel tick, high one clock50 cycle in every two (25 MHz phase)
- pixel_x  in  10  current column from vga_sync
- pixel_y  in  10  current row from vga_sync
- blank  in  1  1 = visible area (vga_sync polarity)
- wr_req  in  1  writer request
- wr_x  in  8  writer column
- wr_y  in  7  writer row
- wr_data  in  DATA_W  writer pixel
- wr_ack  out  1  write accepted this cycle
- clr_start  in  1  start full-screen clear
- clr_color  in  DATA_W  clear colour, sampled at start
- clr_busy  out  1  clear in progress
- wr_oob  out  1  sticky: out-of-range write seen
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- rgb_out  out  DATA_W  display pixel
- rgb_valid  out  1  rgb_out belongs to a visible pixel

Behaviour:
- Reset: rgb_out=0, rgb_valid=0, wr_ack=0, mem_we=0, clr_busy=0, wr_oob=0, FSM=IDLE, clear counter=0, read pipeline flag=0.
- Slot rule, every cycle:
  - Display slot = pix_en & blank. Slot drives mem_addr = (pixel_y>>SCALE_SH)*FB_W + (pixel_x>>SCALE_SH) and mem_we=0.
  - The *160 is implemented as (y<<7)+(y<<5); no multiplier.
  - All other cycles are write slots.
- Display pipeline:
  - Display slot at cycle T; mem_rdata valid at T+1.
  - rgb_out is registered at the end of T+1, so valid from T+2.
  - Fixed latency is 2 clock50 = 1 pixel. The top level delays h_sync/v_sync by one pixel.
  - A pix_en cycle with blank=0 registers rgb_out=0, rgb_valid=0 on the same schedule.
- FSM IDLE:
  - Write slot with wr_req=1: mem_we=1, mem_addr=wr_y*FB_W+wr_x, mem_wdata=wr_data, wr_ack=1 (combinational, same cycle).
  - Writer holds req/x/y/data stable until ack. Back-to-back requests are allowed, up to one ack per write slot.
  - If wr_x>=FB_W or wr_y>=FB_H: wr_ack=1, mem_we=0, wr_oob set. wr_oob is cleared only by reset.
  - clr_start=1: latch clr_color, counter=0, go to CLEAR, clr_busy=1 from the next cycle.
  - If clr_start and a grantable wr_req arrive in the same cycle, the write is served that cycle and CLEAR is entered next.
- FSM CLEAR:
  - Each write slot writes clr_color at address=counter, then counter++.
  - wr_req is never acked (stalls); clr_start is ignored.
  - Display slots keep priority; the counter holds during them.
  - After writing address FB_W*FB_H-1 (19199): go to IDLE and clear the counter; clr_busy falls next cycle.
- Reset mid-clear: returns to IDLE immediately. Partial contents remain in RAM.
- mem_wdata is don't-care when mem_we=0 and is driven 0.
- Throughput guarantees:
  - Writer: at least 1 write per 2 cycles during the visible area; every cycle during blanking.
  - Full clear: at most 38400 cycles + display slots (worst case under 1 frame).

Decomposition:
- Package vga_fb_pkg holds FB_W, FB_H, SCALE_SH, ADDR_W, DATA_W, the FSM state enum {IDLE, CLEAR} and the RGB332 colour constants.
- One sub-module, fb_addr_calc: combinational (x,y) -> address via shift-add. Instantiated twice, once for display and once for writer.
- Keeps both address paths identical.

Test Plan:
- Display read: pixel_x=8, pixel_y=4, blank=1, pix_en=1 -> mem_addr=162, mem_we=0; mem_rdata=0xE0 next cycle -> rgb_out=0xE0, rgb_valid=1 two cycles after the slot.
- Write vs display: wr_req held with (159,119,0x1C) while pix_en=1 & blank=1 -> no ack that cycle. Next cycle (pix_en=0) -> mem_we=1, mem_addr=19199, mem_wdata=0x1C, wr_ack=1.
- Out of range: wr_x=160, wr_y=0 in a write slot -> wr_ack=1, mem_we=0, wr_oob=1; wr_oob stays 1 until reset.
- Clear during blanking (blank=0): clr_start, clr_color=0x03 -> 19200 consecutive writes, addresses 0..19199 with data 0x03. clr_busy falls after the last write. A wr_req raised mid-clear is acked only after clr_busy=0.
- Clear during visible area: counter advances only on pix_en=0 cycles; no write occurs on a display slot; total 38400 cycles.
- Sync reset at counter=5000 during CLEAR -> next cycle clr_busy=0, mem_we=0, rgb_out=0, wr_oob=0. A new clr_start restarts from address 0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
//==============================================================================
// Module      : vga_fb_pkg
// Description : Shared constants, FSM state type and RGB332 colours for the
//               VGA framebuffer arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package vga_fb_pkg;

  localparam int FB_W     = 160;  // framebuffer width in pixels
  localparam int FB_H     = 120;  // framebuffer height in pixels
  localparam int SCALE_SH = 2;    // log2 of screen-to-framebuffer scale
  localparam int ADDR_W   = 15;   // RAM address width
  localparam int DATA_W   = 8;    // pixel width (RGB332)

  // Arbiter write-side state: serving the drawing client, or clearing.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // RGB332 colour constants (RRRGGGBB).
  localparam logic [DATA_W-1:0] RGB_BLACK = 8'h00;
  localparam logic [DATA_W-1:0] RGB_RED   = 8'hE0;
  localparam logic [DATA_W-1:0] RGB_GREEN = 8'h1C;
  localparam logic [DATA_W-1:0] RGB_BLUE  = 8'h03;
  localparam logic [DATA_W-1:0] RGB_WHITE = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/fb_addr_calc.sv
//==============================================================================
// Module      : fb_addr_calc
// Description : Combinational framebuffer address, addr = y*160 + x, built
//               from two shifts and adds so no multiplier is inferred.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fb_addr_calc
  import vga_fb_pkg::*;
(
  input  logic [7:0]        x_i,
  input  logic [6:0]        y_i,
  output logic [ADDR_W-1:0] addr_o
);

  // y*160 = (y<<7) + (y<<5); each term zero-extended to the address width.
  always_comb begin
    addr_o = {1'b0, y_i, 7'b0} + {3'b0, y_i, 5'b0} + {7'b0, x_i};
  end

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
//==============================================================================
// Module      : vga_fb_arbiter
// Description : Shares a single-port 160x120x8 framebuffer RAM between VGA
//               scan-out (fixed display slot, always wins), a drawing client
//               and a built-in clear-screen engine.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clock50,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              blank,
  input  logic              wr_req,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              wr_oob,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb_out,
  output logic              rgb_valid
);

  localparam logic [7:0]        WX_LIM   = 8'(FB_W);
  localparam logic [6:0]        WY_LIM   = 7'(FB_H);
  localparam logic [9:0]        DX_LIM   = 10'(FB_W);
  localparam logic [9:0]        DY_LIM   = 10'(FB_H);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

  // Write-side state and its next-state values.
  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
  logic              oob_q, oob_d;

  // Display read pipeline.
  logic              rd_pend_q;
  logic              rd_vis_q;
  logic [DATA_W-1:0] rgb_q;
  logic              rgb_valid_q;

  // Slot decode and address paths.
  logic              disp_slot;
  logic [9:0]        disp_x;
  logic [9:0]        disp_y;
  logic              disp_in_fb;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_fb;

  assign disp_slot  = pix_en & blank;
  assign disp_x     = pixel_x >> SCALE_SH;
  assign disp_y     = pixel_y >> SCALE_SH;
  // Guards the display read against coordinates past the visible window.
  assign disp_in_fb = (disp_x < DX_LIM) && (disp_y < DY_LIM);
  assign wr_in_fb   = (wr_x < WX_LIM) && (wr_y < WY_LIM);

  fb_addr_calc u_disp_addr (
    .x_i    (disp_x[7:0]),
    .y_i    (disp_y[6:0]),
    .addr_o (disp_addr)
  );

  fb_addr_calc u_wr_addr (
    .x_i    (wr_x),
    .y_i    (wr_y),
    .addr_o (wr_addr)
  );

  // Slot arbitration: the display slot owns the RAM; otherwise the writer
  // (IDLE) or the clear engine (CLEAR) gets the cycle.
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    wr_ack      = 1'b0;
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    oob_d       = oob_q;

    if (disp_slot) begin
      mem_addr = disp_in_fb ? disp_addr : '0;
    end

    case (state_q)
      IDLE: begin
        if (!disp_slot && wr_req) begin
          wr_ack = 1'b1;
          if (wr_in_fb) begin
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
          end else begin
            oob_d = 1'b1;
          end
        end
        if (clr_start) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clr_color;
        end
      end
      CLEAR: begin
        if (!disp_slot) begin
          mem_we    = 1'b1;
          mem_addr  = clr_cnt_q;
          mem_wdata = clr_color_q;
          if (clr_cnt_q == CLR_LAST) begin
            state_d   = IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, clear counter, latched clear colour and sticky out-of-range flag.
  always_ff @(posedge clock50) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      oob_q       <= oob_d;
    end
  end

  // Display pipeline: every pixel tick is tracked so blanked pixels register
  // black/invalid on the same two-cycle schedule as visible ones.
  always_ff @(posedge clock50) begin
    if (reset) begin
      rd_pend_q   <= 1'b0;
      rd_vis_q    <= 1'b0;
      rgb_q       <= RGB_BLACK;
      rgb_valid_q <= 1'b0;
    end else begin
      rd_pend_q <= pix_en;
      rd_vis_q  <= blank;
      if (rd_pend_q) begin
        rgb_q       <= rd_vis_q ? mem_rdata : RGB_BLACK;
        rgb_valid_q <= rd_vis_q;
      end
    end
  end

  assign clr_busy  = (state_q == CLEAR);
  assign wr_oob    = oob_q;
  assign rgb_out   = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

`default_nettype wire
